// File: rtl/uart_mmio_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_mmio_fifo
// Description : Memory-mapped UART controller for the MEM stage. Decodes
//               loads/stores at 0x8xxx_xxxx, buffers TX and RX bytes in two
//               DEPTH-entry FIFOs with sticky overflow flags and occupancy
//               counters, and passes non-UART ALU results through.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_mmio_fifo #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALUOutM,
  input  logic        ValidM,
  input  logic        isLoadM,
  input  logic        isStoreM,
  input  logic [31:0] StoreDataM,
  output logic [31:0] UARTCtrOutM,
  output logic [7:0]  DataIn,
  output logic        DataInValid,
  input  logic        DataInReady,
  input  logic [7:0]  UARTDOut,
  input  logic        DataOutValid,
  output logic        DataOutReady
);

  // Occupancy counters need one extra bit so that "full" (count == DEPTH)
  // is representable; pointers wrap naturally at DEPTH.
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int PTR_W = CNT_W - 1;

  localparam logic [4:0] c_OFF_TXCTL  = 5'h00;
  localparam logic [4:0] c_OFF_RXCTL  = 5'h04;
  localparam logic [4:0] c_OFF_TXDATA = 5'h08;
  localparam logic [4:0] c_OFF_RXDATA = 5'h0C;
  localparam logic [4:0] c_OFF_STATUS = 5'h10;

  logic [7:0]       r_txMem [DEPTH];
  logic [7:0]       r_rxMem [DEPTH];
  logic [PTR_W-1:0] r_txWrPtr, r_txRdPtr, r_rxWrPtr, r_rxRdPtr;
  logic [CNT_W-1:0] r_txCnt, r_rxCnt;
  logic             r_txOvf, r_rxOvf;

  logic       w_isUart;
  logic [4:0] w_offset;
  logic       w_txFull, w_txEmpty, w_rxFull, w_rxEmpty;
  logic       w_txStore, w_txPush, w_txDrop, w_txPop;
  logic       w_rxPop, w_rxPush, w_rxDrop, w_statWr;
  logic [7:0] w_txCnt8, w_rxCnt8;
  logic [31:0] w_rdData;
  logic       w_unusedBits;

  assign w_isUart  = (ALUOutM[31:28] == 4'h8);
  assign w_offset  = ALUOutM[4:0];

  assign w_txFull  = (r_txCnt == CNT_W'(DEPTH));
  assign w_txEmpty = (r_txCnt == '0);
  assign w_rxFull  = (r_rxCnt == CNT_W'(DEPTH));
  assign w_rxEmpty = (r_rxCnt == '0);

  // Every CPU-side effect is qualified by a valid UART access in MEM.
  assign w_txStore = ValidM && w_isUart && isStoreM && (w_offset == c_OFF_TXDATA);
  assign w_txPush  = w_txStore && !w_txFull;
  assign w_txDrop  = w_txStore && w_txFull;
  assign w_txPop   = !w_txEmpty && DataInReady;

  // A pop in the same cycle frees a slot, so a full RX FIFO can still accept.
  assign w_rxPop   = ValidM && w_isUart && isLoadM && (w_offset == c_OFF_RXDATA) && !w_rxEmpty;
  assign w_rxPush  = DataOutValid && (!w_rxFull || w_rxPop);
  assign w_rxDrop  = DataOutValid && w_rxFull && !w_rxPop;
  assign w_statWr  = ValidM && w_isUart && isStoreM && (w_offset == c_OFF_STATUS);

  assign w_txCnt8  = 8'(r_txCnt);
  assign w_rxCnt8  = 8'(r_rxCnt);

  assign DataIn       = r_txMem[r_txRdPtr];
  assign DataInValid  = !w_txEmpty;
  assign DataOutReady = 1'b1;

  // Address bits outside the decode and upper store-data bits are ignored.
  assign w_unusedBits = ^{ALUOutM[27:5], StoreDataM[31:8]};

  // Register read decode; unlisted offsets (including write-only TXDATA) read 0.
  always_comb begin
    w_rdData = 32'h0;
    case (w_offset)
      c_OFF_TXCTL:  w_rdData = {31'b0, !w_txFull};
      c_OFF_RXCTL:  w_rdData = {31'b0, !w_rxEmpty};
      c_OFF_RXDATA: w_rdData = w_rxEmpty ? 32'h0 : {24'b0, r_rxMem[r_rxRdPtr]};
      c_OFF_STATUS: w_rdData = {8'b0, w_txCnt8, w_rxCnt8, 6'b0, r_txOvf, r_rxOvf};
      default:      w_rdData = 32'h0;
    endcase
  end

  // Load-data mux: UART loads get the decoded register, everything else passes through.
  always_comb begin
    UARTCtrOutM = ALUOutM;
    if (w_isUart && isLoadM) begin
      UARTCtrOutM = w_rdData;
    end
  end

  // FIFO storage; contents need no reset since pointers/counts define validity.
  always_ff @(posedge clk) begin
    if (w_txPush) begin
      r_txMem[r_txWrPtr] <= StoreDataM[7:0];
    end
    if (w_rxPush) begin
      r_rxMem[r_rxWrPtr] <= UARTDOut;
    end
  end

  // TX pointers, occupancy and sticky overflow (a new overflow beats a W1C clear).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_txWrPtr <= '0;
      r_txRdPtr <= '0;
      r_txCnt   <= '0;
      r_txOvf   <= 1'b0;
    end else begin
      if (w_txPush) r_txWrPtr <= r_txWrPtr + 1'b1;
      if (w_txPop)  r_txRdPtr <= r_txRdPtr + 1'b1;
      case ({w_txPush, w_txPop})
        2'b10:   r_txCnt <= r_txCnt + 1'b1;
        2'b01:   r_txCnt <= r_txCnt - 1'b1;
        default: r_txCnt <= r_txCnt;
      endcase
      r_txOvf <= w_txDrop || (r_txOvf && !(w_statWr && StoreDataM[1]));
    end
  end

  // RX pointers, occupancy and sticky overflow (a new overflow beats a W1C clear).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rxWrPtr <= '0;
      r_rxRdPtr <= '0;
      r_rxCnt   <= '0;
      r_rxOvf   <= 1'b0;
    end else begin
      if (w_rxPush) r_rxWrPtr <= r_rxWrPtr + 1'b1;
      if (w_rxPop)  r_rxRdPtr <= r_rxRdPtr + 1'b1;
      case ({w_rxPush, w_rxPop})
        2'b10:   r_rxCnt <= r_rxCnt + 1'b1;
        2'b01:   r_rxCnt <= r_rxCnt - 1'b1;
        default: r_rxCnt <= r_rxCnt;
      endcase
      r_rxOvf <= w_rxDrop || (r_rxOvf && !(w_statWr && StoreDataM[0]));
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_mmio_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_mmio_fifo
// Description : Directed self-checking bench for uart_mmio_fifo. Expected load
//               results and TX/RX bytes are queued when stimulus is driven and
//               popped when the DUT output is compared.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_mmio_fifo;

  localparam logic [31:0] c_TXCTL  = 32'h8000_0000;
  localparam logic [31:0] c_RXCTL  = 32'h8000_0004;
  localparam logic [31:0] c_TXDATA = 32'h8000_0008;
  localparam logic [31:0] c_RXDATA = 32'h8000_000C;
  localparam logic [31:0] c_STATUS = 32'h8000_0010;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ALUOutM = '0;
  logic        ValidM = 1'b0;
  logic        isLoadM = 1'b0;
  logic        isStoreM = 1'b0;
  logic [31:0] StoreDataM = '0;
  logic [31:0] UARTCtrOutM;
  logic [7:0]  DataIn;
  logic        DataInValid;
  logic        DataInReady = 1'b0;
  logic [7:0]  UARTDOut = '0;
  logic        DataOutValid = 1'b0;
  logic        DataOutReady;

  int total = 0;
  int bad   = 0;

  logic [31:0] expQ[$];
  logic [7:0]  txQ[$];
  logic [7:0]  rxQ[$];

  uart_mmio_fifo #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst), .ALUOutM(ALUOutM), .ValidM(ValidM),
    .isLoadM(isLoadM), .isStoreM(isStoreM), .StoreDataM(StoreDataM),
    .UARTCtrOutM(UARTCtrOutM), .DataIn(DataIn), .DataInValid(DataInValid),
    .DataInReady(DataInReady), .UARTDOut(UARTDOut),
    .DataOutValid(DataOutValid), .DataOutReady(DataOutReady)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; compares the combinational result at negedge.
  task automatic loadQ(input logic [31:0] addr, input logic valid, input string tag);
    ALUOutM = addr; ValidM = valid; isLoadM = 1'b1;
    #4;
    chk(tag, UARTCtrOutM, expQ.pop_front());
    @(posedge clk); #1;
    ValidM = 1'b0; isLoadM = 1'b0; ALUOutM = '0;
  endtask

  task automatic loadExp(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    expQ.push_back(exp);
    loadQ(addr, 1'b1, tag);
  endtask

  // RXDATA load: the expected byte comes from the RX scoreboard (0 when empty).
  task automatic loadRx(input string tag);
    if (rxQ.size() > 0) expQ.push_back({24'b0, rxQ.pop_front()});
    else                expQ.push_back(32'h0);
    loadQ(c_RXDATA, 1'b1, tag);
  endtask

  task automatic storeOp(input logic [31:0] addr, input logic [31:0] data, input logic valid);
    ALUOutM = addr; StoreDataM = data; ValidM = valid; isStoreM = 1'b1;
    @(posedge clk); #1;
    ValidM = 1'b0; isStoreM = 1'b0; ALUOutM = '0; StoreDataM = '0;
  endtask

  task automatic rxPush(input logic [7:0] b, input logic accept);
    DataOutValid = 1'b1; UARTDOut = b;
    if (accept) rxQ.push_back(b);
    @(posedge clk); #1;
    DataOutValid = 1'b0;
  endtask

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #4;
    chk("rst_DataInValid", {31'b0, DataInValid}, 32'h0);
    chk("rst_DataOutReady", {31'b0, DataOutReady}, 32'h1);
    @(posedge clk); #1;

    loadExp(c_TXCTL, 32'h1, "txctl_reset");
    loadExp(c_RXCTL, 32'h0, "rxctl_reset");
    loadExp(c_STATUS, 32'h0, "status_reset");
    loadExp(32'h0000_1000, 32'h0000_1000, "passthrough");
    loadExp(32'h8000_0014, 32'h0, "unlisted_off14");
    loadExp(c_TXDATA, 32'h0, "load_txdata_wo");
    loadExp(c_STATUS, 32'h0, "status_after_passthrough");

    // Fill TX with DataInReady low, then overflow it
    DataInReady = 1'b0;
    for (int i = 0; i < 8; i++) begin
      storeOp(c_TXDATA, 32'h41 + i, 1'b1);
      txQ.push_back(8'(8'h41 + i));
    end
    loadExp(c_TXCTL, 32'h0, "txctl_full");
    loadExp(c_STATUS, 32'h0008_0000, "status_tx8");
    storeOp(c_TXDATA, 32'h49, 1'b1);
    loadExp(c_STATUS, 32'h0008_0002, "status_tx_ovf");

    // Drain TX
    DataInReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #4;
      chk("tx_valid", {31'b0, DataInValid}, 32'h1);
      chk("tx_byte", {24'b0, DataIn}, {24'b0, txQ.pop_front()});
      @(posedge clk); #1;
    end
    DataInReady = 1'b0;
    #4;
    chk("tx_drained_valid", {31'b0, DataInValid}, 32'h0);
    @(posedge clk); #1;
    storeOp(c_STATUS, 32'h3, 1'b1);
    loadExp(c_STATUS, 32'h0, "status_w1c");

    // Fill RX; 9th byte overflows in the same cycle as a W1C clear (set wins)
    for (int i = 0; i < 8; i++) rxPush(8'(8'h10 + i), 1'b1);
    loadExp(c_RXCTL, 32'h1, "rxctl_nonempty");
    DataOutValid = 1'b1; UARTDOut = 8'h18;
    storeOp(c_STATUS, 32'h1, 1'b1);
    DataOutValid = 1'b0;
    loadExp(c_STATUS, 32'h0000_0801, "status_rx_ovf_setwins");
    for (int i = 0; i < 8; i++) loadRx("rx_byte");
    loadRx("rx_empty_load");
    loadExp(c_STATUS, 32'h0000_0001, "status_rx_empty");
    storeOp(c_STATUS, 32'h1, 1'b1);

    // Full RX with simultaneous push and pop
    for (int i = 0; i < 8; i++) rxPush(8'(8'h20 + i), 1'b1);
    loadExp(c_STATUS, 32'h0000_0800, "status_rx_full");
    DataOutValid = 1'b1; UARTDOut = 8'hAA;
    rxQ.push_back(8'hAA);
    loadRx("rx_full_pushpop");
    DataOutValid = 1'b0;
    loadExp(c_STATUS, 32'h0000_0800, "status_after_pushpop");
    for (int i = 0; i < 8; i++) loadRx("rx_tail_drain");

    // Asynchronous reset mid-burst
    for (int i = 0; i < 3; i++) storeOp(c_TXDATA, 32'h60 + i, 1'b1);
    for (int i = 0; i < 5; i++) rxPush(8'(8'h70 + i), 1'b0);
    loadExp(c_STATUS, 32'h0003_0500, "status_burst");
    #2 rst = 1'b1;
    #1;
    chk("async_rst_DataInValid", {31'b0, DataInValid}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    loadExp(c_STATUS, 32'h0, "status_after_rst");
    loadExp(c_RXCTL, 32'h0, "rxctl_after_rst");

    // ValidM low suppresses side effects; the mux still shows the head
    rxPush(8'h55, 1'b1);
    storeOp(c_TXDATA, 32'h77, 1'b0);
    expQ.push_back(32'h55);
    loadQ(c_RXDATA, 1'b0, "invalid_load_mux");
    loadExp(c_STATUS, 32'h0000_0100, "status_invalid_ops");
    #4;
    chk("invalid_store_no_tx", {31'b0, DataInValid}, 32'h0);
    @(posedge clk); #1;
    loadRx("valid_load_after_invalid");
    loadExp(c_RXCTL, 32'h0, "rxctl_final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
